ym3012_fp_tx: RTL and testbench
===============================

# ym3012_fp_tx

Serial floating-point DAC transmitter for the Konami sound path. It takes pairs of 16-bit signed linear samples (left/right) and converts each to YM3012-format floating point (10-bit two's-complement mantissa plus 3-bit exponent). It serializes the pair LSB-first on SO, together with the SY bit clock and the SH1/SH2 channel latch strobes. It is the output-side counterpart of the YM serial input decoder, and shares its 64-CLK frame and STBI frame sync.

## Interface
- No parameters.
- CLK  in  1  master clock (YM2151 clock); all flops on rising edge.
- nRES  in  1  asynchronous, active-low reset.
- STBI  in  1  frame sync; falling edge restarts the frame.
- L_IN  in  16  left sample, signed two's complement.
- R_IN  in  16  right sample, signed two's complement.
- VALID  in  1  L_IN/R_IN hold a sample pair.
- READY  out  1  input buffer empty; a pair is accepted when VALID & READY at a rising edge.
- SY  out  1  serial bit clock, CLK/2.
- SO  out  1  serial data.
- SH1  out  1  channel-1 (left) latch strobe.
- SH2  out  1  channel-2 (right) latch strobe.
- UNDERRUN  out  1  one-cycle pulse when a frame starts with no new sample.

## Operation
- **Frame counter.** cnt[5:0] increments every CLK and wraps 63→0. slot = cnt[5:1] (32 slots of 2 CLKs each). Slots 0-15 carry the left channel; slots 16-31 carry the right.
- **Channel word.** Each channel word is 16 slots, LSB first:
  - slots 0-2: 0;
  - slots 3-12: mantissa bits 0..9;
  - slots 13-15: exponent bits 0..2.
- **Encoding of 16-bit x.**
  - k = number of consecutive bits from x[14] downward equal to x[15], capped at 6.
  - e = 7 − k, range 1..7; exponent 0 is never emitted.
  - m = (x >>> (e−1))[9:0], arithmetic shift, truncating toward −inf.
- **Input buffer.** One entry, holding 32 bits plus a full flag.
  - READY = ~full.
  - Accepting a pair sets full.
- **Frame register.** Holds 2 encoded 13-bit words.
  - It loads on every transition into cnt=0, whether by wrap or by resync.
  - If the buffer is full at that transition: encode the buffer into the frame register and clear full.
  - If the buffer is empty: keep the previous words and pulse UNDERRUN.
  - UNDERRUN is suppressed until the first pair has been accepted after reset.
- **Simultaneous accept and load.** An accept into an empty buffer in the same cycle as the load does not bypass into the frame. The frame repeats and UNDERRUN pulses; the new pair is sent in the next frame.
- **Resync.**
  - STBI passes through a 2-flop synchronizer plus a delay flop, all reset to 1.
  - A synchronized falling edge forces cnt to 0 on the next edge, and the frame load applies.
  - A resync coinciding with a natural wrap behaves as a single wrap.
- **Output decode.** All outputs are flops loaded from the decode of the next cnt, so there are no combinational output paths. For the cycle in which cnt = n:
  - SY = n[0];
  - SO = word bit for slot n[5:1];
  - SH1 = (16 ≤ n ≤ 31);
  - SH2 = (48 ≤ n ≤ 63).
- **Reset values.**
  - Outputs: SY=0, SO=0, SH1=0, SH2=0, READY=1, UNDERRUN=0.
  - State: cnt=0, full=0, frame words = encode(0) = m 0, e 1.

## Timing
- Frame: 64 CLKs, one stereo pair.
- SO changes only when SY falls, and is stable across SY rising.
- SH1 and SH2 are each 16 CLKs high and 48 low. Each falls at the end of its channel's last exponent slot.
- Input to SO latency:
  - A pair accepted at cnt ≤ 62 is sent from the next cnt=0.
  - A pair accepted at cnt=63 is sent one frame later.
- STBI to restart: STBI is first sampled low at edge E0. cnt reads 0 after E2, i.e. 3 edges.
- Throughput: one pair per 64 CLKs. READY deasserts for the rest of the frame after an accept.
- Reset asserted mid-frame returns every output to its reset value immediately. The first frame after release sends zeros.

## Test plan
- **Reset idle.** Release nRES with no VALID. SY toggles every CLK, SH1 high for cnt 16-31, SH2 high for cnt 48-63. SO is 1 only in slot 13 and slot 29 (exponent=1). UNDERRUN stays 0.
- **Encode corners.** Send L=0x0200, R=0x7FFF.
  - Left: m=0x100, e=2, so SO is 1 in slots 11 and 14.
  - Right: m=0x1FF, e=7, so SO is 1 in slots 19-27, 29, 30, 31.
- **Negative values.** Send L=0x8000, R=0xFFFF.
  - Left: m=0x200, e=7.
  - Right: m=0x3FF, e=1.
- **Handshake.** Hold VALID high continuously. Exactly one accept per frame, READY low between accepts, no UNDERRUN, consecutive distinct pairs appear in consecutive frames.
- **Underrun.** After a valid stream, withhold VALID for one frame. A 1-cycle UNDERRUN pulse at cnt→0 and the previous words are repeated. An accept at cnt=63 also yields UNDERRUN, and that pair is sent in the following frame.
- **Resync.** Drive STBI low at cnt=20. cnt=0 three edges later, the frame reloads, and SH1 drops early. Then reset mid-frame and check all outputs at their reset values.

Source files
------------

// File: rtl/ym3012_fp_tx.sv
// ym3012_fp_tx: serial floating-point DAC transmitter (YM3012 format).
// Converts a stereo pair of 16-bit signed samples into 10-bit mantissa + 3-bit exponent
// words and shifts them out LSB-first over a 64-CLK frame.
// Ports:
//   CLK, nRES      master clock / async active-low reset
//   STBI           frame sync, falling edge restarts the frame
//   L_IN, R_IN     signed sample pair, accepted on VALID & READY
//   READY          one-entry input buffer is empty
//   SY, SO         serial bit clock (CLK/2) and serial data
//   SH1, SH2       left / right channel latch strobes
//   UNDERRUN       one-cycle pulse when a frame starts without a new pair
module ym3012_fp_tx (
  input  logic        CLK,
  input  logic        nRES,
  input  logic        STBI,
  input  logic [15:0] L_IN,
  input  logic [15:0] R_IN,
  input  logic        VALID,
  output logic        READY,
  output logic        SY,
  output logic        SO,
  output logic        SH1,
  output logic        SH2,
  output logic        UNDERRUN
);

  // encode(0): mantissa 0, exponent 1
  localparam logic [12:0] EncZero = 13'h0400;

  // Returns {exponent[2:0], mantissa[9:0]}.
  function automatic logic [12:0] encode(input logic [15:0] x);
    logic [2:0] k;
    logic       run;
    logic [2:0] e;
    logic [9:0] m;
    k   = 3'd0;
    run = 1'b1;
    // Count redundant sign bits below the MSB, saturating at 6.
    for (int i = 0; i < 6; i++) begin
      if (run && (x[14-i] == x[15])) begin
        k = k + 3'd1;
      end else begin
        run = 1'b0;
      end
    end
    e = 3'd7 - k;
    m = 10'($signed(x) >>> (e - 3'd1));
    return {e, m};
  endfunction

  logic [5:0]  cnt_q, cnt_d;
  logic        stbi_s1_q, stbi_s2_q, stbi_s3_q;
  logic        resync, load, accept;
  logic        full_q, full_d;
  logic        started_q, started_d;
  logic [31:0] buf_q, buf_d;
  logic [25:0] frame_q, frame_d;
  logic [4:0]  slot;
  logic [15:0] chan_word;
  logic        ready_q, sy_q, so_q, sh1_q, sh2_q, underrun_q;
  logic        ready_d, sy_d, so_d, sh1_d, sh2_d, underrun_d;

  always_comb begin
    resync    = stbi_s3_q & ~stbi_s2_q;
    cnt_d     = resync ? 6'd0 : cnt_q + 6'd1;
    // A resync landing on the natural wrap is still a single load.
    load      = (cnt_d == 6'd0);
    accept    = VALID & ~full_q;
    buf_d     = accept ? {R_IN, L_IN} : buf_q;
    started_d = started_q | accept;

    // An accept into an empty buffer never bypasses into a concurrent load.
    full_d = full_q;
    if (accept) begin
      full_d = 1'b1;
    end else if (load) begin
      full_d = 1'b0;
    end

    frame_d = frame_q;
    if (load && full_q) begin
      frame_d = {encode(buf_q[31:16]), encode(buf_q[15:0])};
    end

    // Outputs are registered from the next-cycle counter and frame.
    slot      = cnt_d[5:1];
    chan_word = slot[4] ? {frame_d[25:13], 3'b000} : {frame_d[12:0], 3'b000};
    so_d       = chan_word[slot[3:0]];
    sy_d       = cnt_d[0];
    sh1_d      = (cnt_d[5:4] == 2'b01);
    sh2_d      = (cnt_d[5:4] == 2'b11);
    ready_d    = ~full_d;
    underrun_d = load & ~full_q & started_q;
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      cnt_q      <= 6'd0;
      stbi_s1_q  <= 1'b1;
      stbi_s2_q  <= 1'b1;
      stbi_s3_q  <= 1'b1;
      full_q     <= 1'b0;
      started_q  <= 1'b0;
      buf_q      <= 32'd0;
      frame_q    <= {EncZero, EncZero};
      ready_q    <= 1'b1;
      sy_q       <= 1'b0;
      so_q       <= 1'b0;
      sh1_q      <= 1'b0;
      sh2_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      stbi_s1_q  <= STBI;
      stbi_s2_q  <= stbi_s1_q;
      stbi_s3_q  <= stbi_s2_q;
      full_q     <= full_d;
      started_q  <= started_d;
      buf_q      <= buf_d;
      frame_q    <= frame_d;
      ready_q    <= ready_d;
      sy_q       <= sy_d;
      so_q       <= so_d;
      sh1_q      <= sh1_d;
      sh2_q      <= sh2_d;
      underrun_q <= underrun_d;
    end
  end

  assign READY    = ready_q;
  assign SY       = sy_q;
  assign SO       = so_q;
  assign SH1      = sh1_q;
  assign SH2      = sh2_q;
  assign UNDERRUN = underrun_q;

endmodule

// File: tb/tb_ym3012_fp_tx.sv
// Directed bench for ym3012_fp_tx: frame capture of all outputs, compared against
// hand-computed channel words ({exp, mant, 000} as 16 slot bits).
module tb_ym3012_fp_tx;

  logic        CLK;
  logic        nRES;
  logic        STBI;
  logic [15:0] L_IN;
  logic [15:0] R_IN;
  logic        VALID;
  logic        READY, SY, SO, SH1, SH2, UNDERRUN;

  ym3012_fp_tx dut (
    .CLK      (CLK),
    .nRES     (nRES),
    .STBI     (STBI),
    .L_IN     (L_IN),
    .R_IN     (R_IN),
    .VALID    (VALID),
    .READY    (READY),
    .SY       (SY),
    .SO       (SO),
    .SH1      (SH1),
    .SH2      (SH2),
    .UNDERRUN (UNDERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [63:0] SyVec  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] Sh1Vec = 64'h0000_0000_FFFF_0000;
  localparam logic [63:0] Sh2Vec = 64'hFFFF_0000_0000_0000;
  localparam logic [63:0] AllOne = 64'hFFFF_FFFF_FFFF_FFFF;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int present_from = 0;
  logic [15:0] ql[$];
  logic [15:0] qr[$];
  logic [63:0] so_v, sy_v, sh1_v, sh2_v, ur_v, rdy_v, exp_v;
  int acc_cnt, acc_n;

  // Serial pattern for one frame given the two 16-slot channel words.
  function automatic logic [63:0] so_vec(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] v;
    for (int j = 0; j < 64; j++) v[j] = (j < 32) ? l[j / 2] : r[(j - 32) / 2];
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    n = (n + 1) % 64;
  endtask

  // Records one frame, starting at a sample where cnt = 0; feeds queued pairs.
  task automatic capture_frame();
    logic acc;
    acc_cnt = 0;
    acc_n   = -1;
    for (int i = 0; i < 64; i++) begin
      if (ql.size() > 0 && i >= present_from) begin
        VALID = 1'b1;
        L_IN  = ql[0];
        R_IN  = qr[0];
      end else begin
        VALID = 1'b0;
      end
      so_v[i] = SO; sy_v[i] = SY; sh1_v[i] = SH1; sh2_v[i] = SH2;
      ur_v[i] = UNDERRUN; rdy_v[i] = READY;
      acc = VALID & READY;
      step();
      if (acc) begin
        void'(ql.pop_front());
        void'(qr.pop_front());
        acc_cnt++;
        acc_n = i;
      end
    end
    VALID = 1'b0;
  endtask

  task automatic test_reset();
    nRES = 1'b0; STBI = 1'b1; VALID = 1'b0; L_IN = '0; R_IN = '0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({SY, SO, SH1, SH2, READY, UNDERRUN} !== 6'b000010) begin
      errors++;
      $display("FAIL reset_outputs got %b want 000010", {SY, SO, SH1, SH2, READY, UNDERRUN});
    end
    nRES = 1'b1;
    n = 0;
  endtask

  task automatic test_idle();
    capture_frame();
    exp_v = so_vec(16'h2000, 16'h2000);
    checks++; if (so_v !== exp_v) begin errors++; $display("FAIL idle_so got %h want %h", so_v, exp_v); end
    checks++; if (sy_v !== SyVec) begin errors++; $display("FAIL idle_sy got %h want %h", sy_v, SyVec); end
    checks++; if (sh1_v !== Sh1Vec) begin errors++; $display("FAIL idle_sh1 got %h want %h", sh1_v, Sh1Vec); end
    checks++; if (sh2_v !== Sh2Vec) begin errors++; $display("FAIL idle_sh2 got %h want %h", sh2_v, Sh2Vec); end
    checks++; if (ur_v !== 64'd0) begin errors++; $display("FAIL idle_underrun got %h want 0", ur_v); end
    checks++; if (rdy_v !== AllOne) begin errors++; $display("FAIL idle_ready got %h want %h", rdy_v, AllOne); end
  endtask

  task automatic test_encode_corners();
    ql.push_back(16'h0200); qr.push_back(16'h7FFF);
    capture_frame();
    checks++; if (acc_cnt !== 1 || acc_n !== 0) begin errors++; $display("FAIL corners_accept got %0d@%0d want 1@0", acc_cnt, acc_n); end
    checks++; if (rdy_v !== 64'h1) begin errors++; $display("FAIL corners_ready got %h want 1", rdy_v); end
    exp_v = so_vec(16'h2000, 16'h2000);
    checks++; if (so_v !== exp_v) begin errors++; $display("FAIL corners_prev_so got %h want %h", so_v, exp_v); end
    capture_frame();
    exp_v = so_vec(16'h4800, 16'hEFF8);
    checks++; if (so_v !== exp_v) begin errors++; $display("FAIL corners_so got %h want %h", so_v, exp_v); end
    checks++; if (ur_v !== 64'd0) begin errors++; $display("FAIL corners_underrun got %h want 0", ur_v); end
  endtask

  task automatic test_negative();
    ql.push_back(16'h8000); qr.push_back(16'hFFFF);
    capture_frame();
    exp_v = so_vec(16'h4800, 16'hEFF8);
    checks++; if (so_v !== exp_v) begin errors++; $display("FAIL neg_repeat_so got %h want %h", so_v, exp_v); end
    checks++; if (ur_v !== 64'h1) begin errors++; $display("FAIL neg_underrun got %h want 1", ur_v); end
    capture_frame();
    exp_v = so_vec(16'hF000, 16'h3FF8);
    checks++; if (so_v !== exp_v) begin errors++; $display("FAIL neg_so got %h want %h", so_v, exp_v); end
  endtask

  task automatic test_handshake();
    ql.push_back(16'h0001); qr.push_back(16'h0002);
    ql.push_back(16'h1234); qr.push_back(16'hEDCB);
    ql.push_back(16'h0040); qr.push_back(16'hFFC0);
    capture_frame();
    checks++; if (ur_v !== 64'h1) begin errors++; $display("FAIL hs_first_underrun got %h want 1", ur_v); end
    checks++; if (acc_cnt !== 1 || rdy_v !== 64'h1) begin errors++; $display("FAIL hs_f0_accept got %0d rdy %h want 1 rdy 1", acc_cnt, rdy_v); end
    capture_frame();
    exp_v = so_vec(16'h2008, 16'h2010);
    checks++; if (so_v !== exp_v) begin errors++; $display("FAIL hs_a_so got %h want %h", so_v, exp_v); end
    checks++; if (acc_cnt !== 1 || rdy_v !== 64'h1 || ur_v !== 64'd0) begin
      errors++; $display("FAIL hs_f1_flow got acc %0d rdy %h ur %h want 1 1 0", acc_cnt, rdy_v, ur_v);
    end
    capture_frame();
    exp_v = so_vec(16'hA918, 16'hB6E0);
    checks++; if (so_v !== exp_v) begin errors++; $display("FAIL hs_b_so got %h want %h", so_v, exp_v); end
    checks++; if (acc_cnt !== 1 || rdy_v !== 64'h1 || ur_v !== 64'd0) begin
      errors++; $display("FAIL hs_f2_flow got acc %0d rdy %h ur %h want 1 1 0", acc_cnt, rdy_v, ur_v);
    end
    capture_frame();
    exp_v = so_vec(16'h2200, 16'h3E00);
    checks++; if (so_v !== exp_v) begin errors++; $display("FAIL hs_c_so got %h want %h", so_v, exp_v); end
    checks++; if (ur_v !== 64'd0) begin errors++; $display("FAIL hs_c_underrun got %h want 0", ur_v); end
  endtask

  task automatic test_underrun();
    capture_frame();
    exp_v = so_vec(16'h2200, 16'h3E00);
    checks++; if (so_v !== exp_v) begin errors++; $display("FAIL ur_repeat_so got %h want %h", so_v, exp_v); end
    checks++; if (ur_v !== 64'h1) begin errors++; $display("FAIL ur_pulse got %h want 1", ur_v); end
    present_from = 63;
    ql.push_back(16'h4000); qr.push_back(16'hC000);
    capture_frame();
    checks++; if (acc_cnt !== 1 || acc_n !== 63) begin errors++; $display("FAIL ur_late_accept got %0d@%0d want 1@63", acc_cnt, acc_n); end
    capture_frame();
    present_from = 0;
    exp_v = so_vec(16'h2200, 16'h3E00);
    checks++; if (so_v !== exp_v) begin errors++; $display("FAIL ur_late_repeat_so got %h want %h", so_v, exp_v); end
    checks++; if (ur_v !== 64'h1) begin errors++; $display("FAIL ur_late_pulse got %h want 1", ur_v); end
    checks++; if (rdy_v !== 64'd0) begin errors++; $display("FAIL ur_late_ready got %h want 0", rdy_v); end
    capture_frame();
    exp_v = so_vec(16'hE800, 16'hD000);
    checks++; if (so_v !== exp_v) begin errors++; $display("FAIL ur_late_so got %h want %h", so_v, exp_v); end
    checks++; if (ur_v !== 64'd0) begin errors++; $display("FAIL ur_late_clear got %h want 0", ur_v); end
  endtask

  task automatic test_resync();
    checks++; if (READY !== 1'b1) begin errors++; $display("FAIL rs_ready got %b want 1", READY); end
    VALID = 1'b1; L_IN = 16'hFE00; R_IN = 16'h0155;
    step();
    VALID = 1'b0;
    while (n != 20) step();
    STBI = 1'b0;
    step();
    step();
    checks++; if (SH1 !== 1'b1) begin errors++; $display("FAIL rs_sh1_before got %b want 1", SH1); end
    step();
    n = 0;
    checks++;
    if ({SY, SO, SH1, SH2, UNDERRUN} !== 5'b00000) begin
      errors++; $display("FAIL rs_restart got %b want 00000", {SY, SO, SH1, SH2, UNDERRUN});
    end
    STBI = 1'b1;
    capture_frame();
    exp_v = so_vec(16'h3000, 16'h2AA8);
    checks++; if (so_v !== exp_v) begin errors++; $display("FAIL rs_so got %h want %h", so_v, exp_v); end
    checks++; if (sh1_v !== Sh1Vec || sy_v !== SyVec) begin errors++; $display("FAIL rs_timing got %h %h want %h %h", sh1_v, sy_v, Sh1Vec, SyVec); end
    checks++; if (ur_v !== 64'd0) begin errors++; $display("FAIL rs_underrun got %h want 0", ur_v); end
  endtask

  task automatic test_reset_mid_frame();
    VALID = 1'b1; L_IN = 16'h1111; R_IN = 16'h2222;
    step();
    VALID = 1'b0;
    while (n != 17) step();
    checks++;
    if ({SY, SH1, READY} !== 3'b110) begin errors++; $display("FAIL mid_pre got %b want 110", {SY, SH1, READY}); end
    #2 nRES = 1'b0;
    #1;
    checks++;
    if ({SY, SO, SH1, SH2, READY, UNDERRUN} !== 6'b000010) begin
      errors++; $display("FAIL mid_reset got %b want 000010", {SY, SO, SH1, SH2, READY, UNDERRUN});
    end
    @(negedge CLK);
    nRES = 1'b1;
    n = 0;
    capture_frame();
    exp_v = so_vec(16'h2000, 16'h2000);
    checks++; if (so_v !== exp_v) begin errors++; $display("FAIL mid_zero_so got %h want %h", so_v, exp_v); end
    checks++; if (sh2_v !== Sh2Vec || sy_v !== SyVec) begin errors++; $display("FAIL mid_timing got %h %h want %h %h", sh2_v, sy_v, Sh2Vec, SyVec); end
    checks++; if (ur_v !== 64'd0 || rdy_v !== AllOne) begin errors++; $display("FAIL mid_flow got ur %h rdy %h want 0 all-ones", ur_v, rdy_v); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_encode_corners();
    test_negative();
    test_handshake();
    test_underrun();
    test_resync();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
